// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM
// state numbers and the alu_op code also consumed by the ALU control block.
package mips_ctrl_pkg;

    // IR[31:26] values handled by the control FSM
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Visible on the debug state port, so the numbering is fixed
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    // 2'b11 is reserved and never produced
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC next-value select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode the FSM has a sequence for
    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)   || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath. The state register is
// the only flop; every control output is decoded from the current state,
// with mem_ready gating only the FETCH loads and the store completion.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_MEM = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam bit HONOR_READY = (WAIT_MEM != 0);

    // Held as raw bits so the unreachable codes 12-15 stay representable
    logic [3:0] state_q;
    logic [3:0] state_n;
    logic       rdy;

    // With handshaking disabled every memory access completes at once
    assign rdy   = !HONOR_READY || mem_ready;
    assign state = state_q;

    // State register, asynchronously forced to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_n;
    end

    // Next-state sequencing
    always_comb begin
        state_n = S_FETCH;
        case (state_q)
            S_FETCH:     state_n = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_n = S_MEM_ADDR;
                    OP_RTYPE:     state_n = S_R_EXEC;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_J:         state_n = S_JUMP;
                    OP_ADDI:      state_n = S_ADDI_EXEC;
                    default:      state_n = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_n = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_n = rdy ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_n = S_FETCH;
            S_MEM_WRITE: state_n = rdy ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_n = S_R_WB;
            S_R_WB:      state_n = S_FETCH;
            S_BRANCH:    state_n = S_FETCH;
            S_JUMP:      state_n = S_FETCH;
            S_ADDI_EXEC: state_n = S_ADDI_WB;
            S_ADDI_WB:   state_n = S_FETCH;
            default:     state_n = S_FETCH;
        endcase
    end

    // Output decode; anything not set in a state stays inactive
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed
                // together with the instruction word
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = rdy;
                pc_write  = rdy;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                alu_src_b = SRCB_IMMSH;
                illegal   = !op_supported(opcode);
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = rdy;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle
// by cycle and compares the state and the full control word to hand-derived
// values. A second instance with WAIT_MEM=0 covers the no-handshake build.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    logic       n_pc_write, n_pc_write_cond, n_iord, n_mem_read, n_mem_write, n_ir_write;
    logic       n_mem_to_reg, n_reg_dst, n_reg_write, n_alu_src_a, n_instr_done, n_illegal;
    logic [1:0] n_alu_src_b, n_alu_op, n_pc_source;
    logic [3:0] n_state;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_MEM(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal(illegal),
        .state(state)
    );

    multicycle_control #(.WAIT_MEM(0)) dut_nw (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .iord(n_iord),
        .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
        .mem_to_reg(n_mem_to_reg), .reg_dst(n_reg_dst), .reg_write(n_reg_write),
        .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
        .pc_source(n_pc_source), .instr_done(n_instr_done), .illegal(n_illegal),
        .state(n_state)
    );

    // Control word: pcw pwc iord mrd mwr irw m2r rdst rw asa asb[2] aop[2] psrc[2] done ill
    logic [17:0] ctl, n_ctl;
    assign ctl   = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, instr_done, illegal};
    assign n_ctl = {n_pc_write, n_pc_write_cond, n_iord, n_mem_read, n_mem_write, n_ir_write,
                    n_mem_to_reg, n_reg_dst, n_reg_write, n_alu_src_a, n_alu_src_b, n_alu_op,
                    n_pc_source, n_instr_done, n_illegal};

    localparam logic [17:0] C_F0  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0; // FETCH, stalled
    localparam logic [17:0] C_F1  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0; // FETCH, ready
    localparam logic [17:0] C_DEC = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] C_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
    localparam logic [17:0] C_ADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0; // MEM_ADDR / ADDI_EXEC
    localparam logic [17:0] C_MRD = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_MWB = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [17:0] C_MW0 = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_MW1 = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] C_REX = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] C_RWB = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [17:0] C_AWB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
    localparam logic [17:0] C_BR  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [17:0] C_JMP = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;

    // Each task starts at a falling edge with the FSM in FETCH and leaves it
    // at the falling edge of the next FETCH cycle.

    task automatic test_reset();
        logic        mr [7];
        logic [3:0]  es [7];
        logic [17:0] ec [7];
        reset = 1'b1; opcode = 6'b000000; mem_ready = 1'b0;
        @(negedge clk); #1;
        vec++;
        if (state !== 4'd0 || ctl !== C_F0) begin
            err++; $display("FAIL reset_state: state=%0d ctl=%b, want state=0 ctl=%b", state, ctl, C_F0);
        end
        reset = 1'b0;
        @(negedge clk);
        // Run an R-type into R_EXEC, then hit reset mid-instruction
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec++;
            if (state !== i[3:0]*((i == 2) ? 4'd3 : 4'd1) || ctl !== ((i == 0) ? C_F1 : (i == 1) ? C_DEC : C_REX)) begin
                err++; $display("FAIL reset_prefix cyc%0d: state=%0d ctl=%b", i, state, ctl);
            end
            @(negedge clk);
        end
        // Back in R_EXEC's successor? No: the loop above ended at R_WB's edge, so
        // check R_WB is reached only if reset is not applied; instead apply now.
        #1; mem_ready = 1'b0; reset = 1'b1; #1;
        vec++;
        if (state !== 4'd0 || mem_read !== 1'b1 || reg_write !== 1'b0 || ctl !== C_F0) begin
            err++; $display("FAIL reset_async: state=%0d mem_read=%b reg_write=%b, want 0/1/0", state, mem_read, reg_write);
        end
        @(negedge clk);
        reset = 1'b0;
        // Full R-type after reset: FETCH, DECODE, R_EXEC, R_WB(done), then FETCH idle
        mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        es = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0, 4'd0};
        ec = '{C_F1, C_DEC, C_REX, C_RWB, C_F0, C_F0, C_F0};
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i]; #1;
            vec++;
            if (state !== es[i] || ctl !== ec[i]) begin
                err++; $display("FAIL rtype cyc%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw();
        logic        mr [6];
        logic [3:0]  es [6];
        logic [17:0] ec [6];
        opcode = 6'b100011;
        mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        ec = '{C_F1, C_DEC, C_ADR, C_MRD, C_MWB, C_F0};
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i]; #1;
            vec++;
            if (state !== es[i] || ctl !== ec[i]) begin
                err++; $display("FAIL lw cyc%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_stall();
        logic        mr [8];
        logic [3:0]  es [8];
        logic [17:0] ec [8];
        opcode = 6'b101011;
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
        ec = '{C_F1, C_DEC, C_ADR, C_MW0, C_MW0, C_MW0, C_MW1, C_F0};
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i]; #1;
            vec++;
            if (state !== es[i] || ctl !== ec[i]) begin
                err++; $display("FAIL sw_stall cyc%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_beq_j();
        logic [3:0]  es [4];
        logic [17:0] ec [4];
        opcode = 6'b000100;
        es = '{4'd0, 4'd1, 4'd8, 4'd0};
        ec = '{C_F1, C_DEC, C_BR, C_F0};
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i != 3); #1;
            vec++;
            if (state !== es[i] || ctl !== ec[i]) begin
                err++; $display("FAIL beq cyc%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
            end
            @(negedge clk);
        end
        opcode = 6'b000010;
        es = '{4'd0, 4'd1, 4'd9, 4'd0};
        ec = '{C_F1, C_DEC, C_JMP, C_F0};
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i != 3); #1;
            vec++;
            if (state !== es[i] || ctl !== ec[i]) begin
                err++; $display("FAIL jump cyc%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fetch_stall();
        logic        mr [7];
        logic [3:0]  es [7];
        logic [17:0] ec [7];
        opcode = 6'b001000;
        mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        es = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
        ec = '{C_F0, C_F0, C_F1, C_DEC, C_ADR, C_AWB, C_F0};
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i]; #1;
            vec++;
            if (state !== es[i] || ctl !== ec[i]) begin
                err++; $display("FAIL fetch_stall cyc%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  es [3];
        logic [17:0] ec [3];
        opcode = 6'b111111;
        es = '{4'd0, 4'd1, 4'd0};
        ec = '{C_F1, C_ILL, C_F0};
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i != 2); #1;
            vec++;
            if (state !== es[i] || ctl !== ec[i]) begin
                err++; $display("FAIL illegal cyc%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_nowait();
        logic [3:0]  es [6];
        logic [17:0] ec [6];
        // Realign the no-wait instance, which has been free-running
        reset = 1'b1; #1; reset = 1'b0;
        opcode = 6'b100011; mem_ready = 1'b0;
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        ec = '{C_F1, C_DEC, C_ADR, C_MRD, C_MWB, C_F1};
        for (int i = 0; i < 6; i++) begin
            #1;
            vec++;
            if (n_state !== es[i] || n_ctl !== ec[i]) begin
                err++; $display("FAIL nowait_lw cyc%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, n_state, n_ctl, es[i], ec[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq_j();
        test_fetch_stall();
        test_illegal();
        test_nowait();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
